// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port. It services one request at a time,
// adds programmable wait states and returns a one-cycle rValid strobe. Bit 0 is the MSB.
module dmem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [0:WIDTH-1] addr,
    input  logic [0:WIDTH-1] wData,
    input  logic             writeEnable,
    input  logic [0:1]       dsize,
    output logic [0:WIDTH-1] rData,
    output logic             rValid,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? '0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [AW-1:0]    lat_idx;
    logic [0:1]       lat_off;
    logic [0:WIDTH-1] lat_wdata;
    logic             lat_we;
    logic [0:1]       lat_size;

    logic [0:WIDTH-1] mem [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic [AW-1:0]    op_idx;
    logic [0:1]       op_off;
    logic [0:WIDTH-1] op_wdata;
    logic             op_we;
    logic [0:1]       op_size;
    logic             op_err;
    logic [0:WIDTH-1] cur_word;
    logic [0:7]       lane_byte;
    logic [0:15]      lane_half;
    logic [0:WIDTH-1] resp_data;
    logic [0:WIDTH-1] wr_word;
    logic [0:3]       be;

    // Upper address bits alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[0:WIDTH-3-AW];

    assign accept = (state == IDLE) && req_ready && req_valid;
    assign commit = !reset && ((accept && (WAIT_STATES == 0)) ||
                               ((state == BUSY) && (wait_cnt == '0)));

    // With no wait states the commit edge is the accept edge, so the bus fields are used directly.
    always_comb begin
        op_idx   = lat_idx;
        op_off   = lat_off;
        op_wdata = lat_wdata;
        op_we    = lat_we;
        op_size  = lat_size;
        if (state == IDLE) begin
            op_idx   = addr[WIDTH-2-AW +: AW];
            op_off   = addr[WIDTH-2:WIDTH-1];
            op_wdata = wData;
            op_we    = writeEnable;
            op_size  = dsize;
        end
    end

    always_comb begin
        op_err = 1'b0;
        case (op_size)
            2'b01:   op_err = op_off[1];
            2'b10:   op_err = (op_off != 2'b00);
            2'b11:   op_err = 1'b1;
            default: op_err = 1'b0;
        endcase
    end

    always_comb begin
        cur_word  = mem[op_idx];
        lane_byte = '0;
        case (op_off)
            2'b00:   lane_byte = cur_word[0:7];
            2'b01:   lane_byte = cur_word[8:15];
            2'b10:   lane_byte = cur_word[16:23];
            default: lane_byte = cur_word[24:31];
        endcase
        lane_half = op_off[0] ? cur_word[16:31] : cur_word[0:15];
        resp_data = '0;
        if (!op_we && !op_err) begin
            case (op_size)
                2'b00:   resp_data = {{(WIDTH-8){1'b0}}, lane_byte};
                2'b01:   resp_data = {{(WIDTH-16){1'b0}}, lane_half};
                default: resp_data = cur_word;
            endcase
        end
    end

    always_comb begin
        wr_word = op_wdata;
        be      = '0;
        case (op_size)
            2'b00: begin
                wr_word = {4{op_wdata[24:31]}};
                case (op_off)
                    2'b00:   be = 4'b1000;
                    2'b01:   be = 4'b0100;
                    2'b10:   be = 4'b0010;
                    default: be = 4'b0001;
                endcase
            end
            2'b01: begin
                wr_word = {2{op_wdata[16:31]}};
                be      = op_off[0] ? 4'b0011 : 4'b1100;
            end
            default: begin
                wr_word = op_wdata;
                be      = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[op_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rValid    <= 1'b0;
            rData     <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_off   <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    rValid    <= 1'b0;
                    rData     <= '0;
                    err       <= 1'b0;
                    if (accept) begin
                        lat_idx   <= op_idx;
                        lat_off   <= op_off;
                        lat_wdata <= op_wdata;
                        lat_we    <= op_we;
                        lat_size  <= op_size;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state  <= RESP;
                            rValid <= 1'b1;
                            rData  <= resp_data;
                            err    <= op_err;
                        end else begin
                            state    <= BUSY;
                            wait_cnt <= WS_LAST;
                        end
                    end
                end
                BUSY: begin
                    if (wait_cnt == '0) begin
                        state  <= RESP;
                        rValid <= 1'b1;
                        rData  <= resp_data;
                        err    <= op_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rValid    <= 1'b0;
                    rData     <= '0;
                    err       <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rValid    <= 1'b0;
                    rData     <= '0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: dut0 uses 2 wait states and dut1 uses 0.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid[2], req_ready[2], writeEnable[2], rValid[2], err[2];
    logic [0:31] addr[2], wData[2], rData[2];
    logic [0:1]  dsize[2];

    localparam logic [0:1] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .addr(addr[0]), .wData(wData[0]), .writeEnable(writeEnable[0]), .dsize(dsize[0]),
        .rData(rData[0]), .rValid(rValid[0]), .err(err[0]));

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .addr(addr[1]), .wData(wData[1]), .writeEnable(writeEnable[1]), .dsize(dsize[1]),
        .rData(rData[1]), .rValid(rValid[1]), .err(err[1]));

    typedef struct {
        logic [0:31] data;
        logic        e;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        q0[$], q1[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [0:31] act, input logic [0:31] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int unsigned ws(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic mon(input int d);
        exp_t e;
        bit   empty;
        if (rValid[d] === 1'b1) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid dut%0d actual=1 required=0", d);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check({e.name, "_rdata"}, rData[d], e.data);
                check({e.name, "_err"}, {31'b0, err[d]}, {31'b0, e.e});
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_ready_in_resp"}, {31'b0, req_ready[d]}, 32'd0);
            end
        end else begin
            check("idle_rdata_zero", rData[d], 32'd0);
            check("idle_err_zero", {31'b0, err[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 2) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic issue(input int d, input logic we, input logic [0:1] sz, input logic [0:31] a,
                         input logic [0:31] wd, input logic [0:31] ed, input logic ee,
                         input string name, input bit push, input bit hold,
                         output int unsigned acc);
        int   n;
        exp_t e;
        n   = 0;
        acc = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1) begin
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL %s_ready_timeout actual=0 required=1", name);
                return;
            end
            @(negedge clk);
        end
        req_valid[d]   = 1'b1;
        writeEnable[d] = we;
        dsize[d]       = sz;
        addr[d]        = a;
        wData[d]       = wd;
        acc            = cyc + 1;
        if (push) begin
            e.data = ed;
            e.e    = ee;
            e.cyc  = acc + ws(d);
            e.name = name;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        check({name, "_ready_low"}, {31'b0, req_ready[d]}, 32'd0);
        if (!hold) req_valid[d] = 1'b0;
    endtask

    int unsigned a1, a2;

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]   = 1'b0;
            writeEnable[d] = 1'b0;
            dsize[d]       = SZ_W;
            addr[d]        = '0;
            wData[d]       = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'b0, req_ready[d]}, 32'd0);
            check("reset_rvalid", {31'b0, rValid[d]}, 32'd0);
            check("reset_rdata", rData[d], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("ready_after_reset", {31'b0, req_ready[d]}, 32'd1);

        issue(0, 1, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st_w10", 1, 0, a1);
        issue(0, 0, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w10", 1, 0, a1);
        issue(0, 1, SZ_B, 32'h11, 32'h000000AA, 32'h0, 0, "st_b11", 1, 0, a1);
        issue(0, 0, SZ_W, 32'h10, 32'h0, 32'hDEAABEEF, 0, "ld_w10_merged", 1, 0, a1);
        issue(0, 0, SZ_B, 32'h12, 32'h0, 32'h000000BE, 0, "ld_b12", 1, 0, a1);
        issue(0, 0, SZ_B, 32'h10, 32'h0, 32'h000000DE, 0, "ld_b10", 1, 0, a1);
        issue(0, 0, SZ_B, 32'h13, 32'h0, 32'h000000EF, 0, "ld_b13", 1, 0, a1);
        issue(0, 0, SZ_H, 32'h12, 32'h0, 32'h0000BEEF, 0, "ld_h12", 1, 0, a1);
        issue(0, 0, SZ_H, 32'h10, 32'h0, 32'h0000DEAA, 0, "ld_h10", 1, 0, a1);

        issue(0, 0, SZ_W, 32'h13, 32'h0, 32'h0, 1, "ld_w13_misal", 1, 0, a1);
        issue(0, 1, SZ_H, 32'h11, 32'h00001234, 32'h0, 1, "st_h11_misal", 1, 0, a1);
        issue(0, 0, SZ_W, 32'h10, 32'h0, 32'hDEAABEEF, 0, "ld_w10_after_err", 1, 0, a1);
        issue(0, 0, SZ_R, 32'h10, 32'h0, 32'h0, 1, "ld_rsvd", 1, 0, a1);

        issue(0, 1, SZ_W, 32'h30, 32'h00000000, 32'h0, 0, "st_w30", 1, 0, a1);
        issue(0, 1, SZ_B, 32'h33, 32'h11223344, 32'h0, 0, "st_b33", 1, 0, a1);
        issue(0, 1, SZ_H, 32'h30, 32'h0000ABCD, 32'h0, 0, "st_h30", 1, 0, a1);
        issue(0, 0, SZ_W, 32'h30, 32'h0, 32'hABCD0044, 0, "ld_w30", 1, 0, a1);
        issue(0, 0, SZ_H, 32'h32, 32'h0, 32'h00000044, 0, "ld_h32", 1, 0, a1);

        // Reset lands in BUSY: the pending store must be dropped without a response.
        issue(0, 1, SZ_W, 32'h20, 32'h0BADF00D, 32'h0, 0, "st_w20", 1, 0, a1);
        issue(0, 1, SZ_W, 32'h20, 32'h12345678, 32'h0, 0, "st_w20_abort", 0, 0, a1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ready", {31'b0, req_ready[0]}, 32'd0);
        check("midreset_rvalid", {31'b0, rValid[0]}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", {31'b0, req_ready[0]}, 32'd1);
        issue(0, 0, SZ_W, 32'h20, 32'h0, 32'h0BADF00D, 0, "ld_w20_kept", 1, 0, a1);

        issue(0, 0, SZ_W, 32'h00001010, 32'h0, 32'hDEAABEEF, 0, "ld_alias", 1, 1, a1);
        writeEnable[0] = 1'b1;
        addr[0]        = 32'h10;
        wData[0]       = 32'hFFFFFFFF;
        dsize[0]       = SZ_W;
        issue(0, 0, SZ_W, 32'h10, 32'h0, 32'hDEAABEEF, 0, "ld_b2b", 1, 0, a2);
        check("b2b_spacing", a2 - a1, 32'd4);

        issue(1, 1, SZ_W, 32'h40, 32'hCAFEF00D, 32'h0, 0, "ws0_st_w40", 1, 0, a1);
        issue(1, 0, SZ_W, 32'h40, 32'h0, 32'hCAFEF00D, 0, "ws0_ld_w40", 1, 0, a1);
        issue(1, 0, SZ_H, 32'h43, 32'h0, 32'h0, 1, "ws0_ld_h43_misal", 1, 0, a1);
        issue(1, 0, SZ_B, 32'h41, 32'h0, 32'h000000FE, 0, "ws0_ld_b41", 1, 0, a1);

        repeat (8) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
